// File: rtl/bullet_arbiter.sv
// bullet_arbiter: shares the bullet slot pool between the two player tanks.
// Optional build macro BULLET_ARB_FIXED_PRIO_EN: player 0 wins ties, no RR pointer.
module bullet_arbiter #(
    parameter int SLOTS          = 4,
    parameter int COOLDOWN       = 800000,
    parameter int PER_PLAYER_MAX = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             game_over,
    input  logic [1:0]       fire,
    input  logic [3:0]       fire_dir,
    input  logic [19:0]      fire_x,
    input  logic [19:0]      fire_y,
    input  logic [SLOTS-1:0] slot_free,
    output logic             launch,
    output logic [2:0]       launch_slot,
    output logic             launch_owner,
    output logic [1:0]       launch_dir,
    output logic [9:0]       launch_x,
    output logic [9:0]       launch_y,
    output logic [SLOTS-1:0] slot_busy,
    output logic [1:0]       ack
);

    localparam logic [19:0] CD_INIT = 20'(COOLDOWN);
    localparam logic [3:0]  MAX_OWN = 4'(PER_PLAYER_MAX);

    logic [1:0]       fire_q, fire_d;
    logic [1:0]       pend_q, pend_d;
    logic [1:0]       dir_q [2];
    logic [1:0]       dir_d [2];
    logic [9:0]       x_q [2];
    logic [9:0]       x_d [2];
    logic [9:0]       y_q [2];
    logic [9:0]       y_d [2];
    logic [19:0]      cd_q [2];
    logic [19:0]      cd_d [2];
    logic [2:0]       owned_q [2];
    logic [2:0]       owned_d [2];
    logic [SLOTS-1:0] busy_q, busy_d;
    logic [SLOTS-1:0] owner_q, owner_d;
    logic             launch_q, launch_d;
    logic [2:0]       lslot_q, lslot_d;
    logic             lown_q, lown_d;
    logic [1:0]       ldir_q, ldir_d;
    logic [9:0]       lx_q, lx_d;
    logic [9:0]       ly_q, ly_d;
    logic [1:0]       ack_q, ack_d;
`ifndef BULLET_ARB_FIXED_PRIO_EN
    logic             rr_q, rr_d;
`endif

    logic             free_any;
    logic [2:0]       free_idx;
    logic [1:0]       elig;
    logic             grant;
    logic             win;
    logic [1:0]       gnt;

    // Pick the lowest free slot and resolve which eligible player wins
    always_comb begin
        free_any = ~&busy_q;
        free_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = 3'(i);
        end
        for (int p = 0; p < 2; p++) begin
            elig[p] = pend_q[p] && (cd_q[p] == '0) &&
                      ({1'b0, owned_q[p]} < MAX_OWN) &&
                      free_any && !game_over;
        end
        grant = |elig;
`ifdef BULLET_ARB_FIXED_PRIO_EN
        win = ~elig[0];
`else
        win = (&elig) ? rr_q : ~elig[0];
`endif
        gnt = '0;
        if (grant) gnt[win] = 1'b1;
    end

    // Next-state: request capture, cooldowns, occupancy and launch outputs
    always_comb begin
        logic [1:0]       req;
        logic [SLOTS-1:0] freed;
        logic [2:0]       dec [2];
        req     = fire & ~fire_q;
        fire_d  = fire;
        freed   = slot_free & busy_q;
        dec[0]  = '0;
        dec[1]  = '0;
        owner_d = owner_q;
        for (int i = 0; i < SLOTS; i++) begin
            if (freed[i]) dec[owner_q[i]] = dec[owner_q[i]] + 3'd1;
            if (grant && free_idx == 3'(i)) owner_d[i] = win;
        end
        busy_d = busy_q & ~freed;
        if (grant) busy_d = busy_d | (SLOTS'(1) << free_idx);
        for (int p = 0; p < 2; p++) begin
            pend_d[p]  = pend_q[p];
            dir_d[p]   = dir_q[p];
            x_d[p]     = x_q[p];
            y_d[p]     = y_q[p];
            cd_d[p]    = cd_q[p];
            owned_d[p] = owned_q[p] - dec[p] + {2'b0, gnt[p]};
            if (game_over) begin
                pend_d[p] = 1'b0;
            end else if (gnt[p]) begin
                pend_d[p] = 1'b0;
            end else if (req[p] && !pend_q[p]) begin
                pend_d[p] = 1'b1;
                dir_d[p]  = fire_dir[2*p +: 2];
                x_d[p]    = fire_x[10*p +: 10];
                y_d[p]    = fire_y[10*p +: 10];
            end
            if (gnt[p]) cd_d[p] = CD_INIT;
            else if (cd_q[p] != '0) cd_d[p] = cd_q[p] - 20'd1;
        end
        launch_d = grant;
        ack_d    = gnt;
        lslot_d  = lslot_q;
        lown_d   = lown_q;
        ldir_d   = ldir_q;
        lx_d     = lx_q;
        ly_d     = ly_q;
        if (grant) begin
            lslot_d = free_idx;
            lown_d  = win;
            ldir_d  = dir_q[win];
            lx_d    = x_q[win];
            ly_d    = y_q[win];
        end
`ifndef BULLET_ARB_FIXED_PRIO_EN
        rr_d = grant ? ~win : rr_q;
`endif
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fire_q   <= '0;
            pend_q   <= '0;
            for (int p = 0; p < 2; p++) begin
                dir_q[p]   <= '0;
                x_q[p]     <= '0;
                y_q[p]     <= '0;
                cd_q[p]    <= '0;
                owned_q[p] <= '0;
            end
            busy_q   <= '0;
            owner_q  <= '0;
            launch_q <= 1'b0;
            lslot_q  <= '0;
            lown_q   <= 1'b0;
            ldir_q   <= '0;
            lx_q     <= '0;
            ly_q     <= '0;
            ack_q    <= '0;
`ifndef BULLET_ARB_FIXED_PRIO_EN
            rr_q     <= 1'b0;
`endif
        end else begin
            fire_q   <= fire_d;
            pend_q   <= pend_d;
            for (int p = 0; p < 2; p++) begin
                dir_q[p]   <= dir_d[p];
                x_q[p]     <= x_d[p];
                y_q[p]     <= y_d[p];
                cd_q[p]    <= cd_d[p];
                owned_q[p] <= owned_d[p];
            end
            busy_q   <= busy_d;
            owner_q  <= owner_d;
            launch_q <= launch_d;
            lslot_q  <= lslot_d;
            lown_q   <= lown_d;
            ldir_q   <= ldir_d;
            lx_q     <= lx_d;
            ly_q     <= ly_d;
            ack_q    <= ack_d;
`ifndef BULLET_ARB_FIXED_PRIO_EN
            rr_q     <= rr_d;
`endif
        end
    end

    assign launch       = launch_q;
    assign launch_slot  = lslot_q;
    assign launch_owner = lown_q;
    assign launch_dir   = ldir_q;
    assign launch_x     = lx_q;
    assign launch_y     = ly_q;
    assign slot_busy    = busy_q;
    assign ack          = ack_q;

endmodule

// File: tb/tb_bullet_arbiter.sv
// tb_bullet_arbiter: scoreboard bench for bullet_arbiter.
// Stimulus queues expected launches; a monitor pops and compares them.
module tb_bullet_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        game_over;
    logic [1:0]  fire;
    logic [3:0]  fire_dir;
    logic [19:0] fire_x;
    logic [19:0] fire_y;
    logic [3:0]  slot_free;
    logic        launch;
    logic [2:0]  launch_slot;
    logic        launch_owner;
    logic [1:0]  launch_dir;
    logic [9:0]  launch_x;
    logic [9:0]  launch_y;
    logic [3:0]  slot_busy;
    logic [1:0]  ack;

    typedef struct {
        int         cyc;
        logic [2:0] slot;
        logic       owner;
        logic [1:0] dir;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   c;

    bullet_arbiter #(.SLOTS(4), .COOLDOWN(4), .PER_PLAYER_MAX(2)) dut (
        .clk(clk), .reset(reset), .game_over(game_over),
        .fire(fire), .fire_dir(fire_dir), .fire_x(fire_x), .fire_y(fire_y),
        .slot_free(slot_free), .launch(launch), .launch_slot(launch_slot),
        .launch_owner(launch_owner), .launch_dir(launch_dir),
        .launch_x(launch_x), .launch_y(launch_y),
        .slot_busy(slot_busy), .ack(ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input int cy, input int sl, input int ow,
                        input int d, input int x, input int y);
        exp_t e;
        e.cyc = cy; e.slot = 3'(sl); e.owner = 1'(ow);
        e.dir = 2'(d); e.x = 10'(x); e.y = 10'(y);
        exp_q.push_back(e);
    endtask

    task automatic setp(input int p, input int d, input int x, input int y);
        fire_dir[2*p +: 2] = 2'(d);
        fire_x[10*p +: 10] = 10'(x);
        fire_y[10*p +: 10] = 10'(y);
    endtask

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fire = '0;
        game_over = 1'b0;
        slot_free = '0;
        @(negedge clk);
        chk("rst_launch", 32'(launch), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_busy", 32'(slot_busy), 0);
        chk("rst_slot", 32'(launch_slot), 0);
        chk("rst_owner", 32'(launch_owner), 0);
        chk("rst_xy", {launch_dir, launch_x, launch_y}, 0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: compare every launch against the head of the queue
    always @(negedge clk) begin
        if (launch) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_launch @cyc %0d: slot %0d owner %0d",
                         cyc, launch_slot, launch_owner);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("launch_cyc", cyc, e.cyc);
                chk("launch_slot", 32'(launch_slot), 32'(e.slot));
                chk("launch_owner", 32'(launch_owner), 32'(e.owner));
                chk("launch_dir", 32'(launch_dir), 32'(e.dir));
                chk("launch_x", 32'(launch_x), 32'(e.x));
                chk("launch_y", 32'(launch_y), 32'(e.y));
                chk("ack", 32'(ack), e.owner ? 32'd2 : 32'd1);
            end
        end else begin
            if (ack != 2'b00) begin
                total++;
                bad++;
                $display("FAIL stray_ack @cyc %0d: got %0h want 0", cyc, ack);
            end
            if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL missed_launch: got none want slot %0d at cyc %0d",
                         e.slot, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        fire = '0;
        game_over = 1'b0;
        fire_dir = '0;
        fire_x = '0;
        fire_y = '0;
        slot_free = '0;
        @(negedge clk);

        // Single fire, 2-cycle latency
        do_reset();
        c = cyc;
        setp(0, 2, 100, 200);
        fire = 2'b01;
        push(c + 2, 0, 0, 2, 100, 200);
        goto(c + 1); fire = 2'b00;
        goto(c + 2); chk("s1_busy", 32'(slot_busy), 32'h1);

        // Round-robin in both directions
        do_reset();
        c = cyc;
        setp(0, 1, 11, 21);
        setp(1, 3, 31, 41);
        fire = 2'b11;
        push(c + 2, 0, 0, 1, 11, 21);
        push(c + 3, 1, 1, 3, 31, 41);
        goto(c + 1); fire = 2'b00;
        goto(c + 4); slot_free = 4'b0011;
        goto(c + 5); slot_free = 4'b0000;
        chk("s2_freed", 32'(slot_busy), 0);
        goto(c + 10); setp(0, 0, 50, 60); fire = 2'b01;
        push(c + 12, 0, 0, 0, 50, 60);
        goto(c + 11); fire = 2'b00;
        goto(c + 20); setp(0, 2, 70, 80); setp(1, 1, 90, 99); fire = 2'b11;
        push(c + 22, 1, 1, 1, 90, 99);
        push(c + 23, 2, 0, 2, 70, 80);
        goto(c + 21); fire = 2'b00;
        goto(c + 24); chk("s2_busy", 32'(slot_busy), 32'h7);

        // Per-player quota holds the third request
        do_reset();
        c = cyc;
        setp(0, 1, 1, 2); fire = 2'b01;
        push(c + 2, 0, 0, 1, 1, 2);
        goto(c + 1); fire = 2'b00;
        goto(c + 10); setp(0, 2, 3, 4); fire = 2'b01;
        push(c + 12, 1, 0, 2, 3, 4);
        goto(c + 11); fire = 2'b00;
        goto(c + 20); setp(0, 3, 5, 6); fire = 2'b01;
        goto(c + 21); fire = 2'b00;
        goto(c + 25); chk("s3_held", 32'(slot_busy), 32'h3);
        slot_free = 4'b0001;
        push(c + 27, 0, 0, 3, 5, 6);
        goto(c + 26); slot_free = 4'b0000;
        goto(c + 28); chk("s3_busy", 32'(slot_busy), 32'h3);

        // Cooldown delays an early second request
        do_reset();
        c = cyc;
        setp(0, 0, 7, 8); fire = 2'b01;
        push(c + 2, 0, 0, 0, 7, 8);
        goto(c + 1); fire = 2'b00;
        goto(c + 4); setp(0, 1, 9, 10); fire = 2'b01;
        push(c + 7, 1, 0, 1, 9, 10);
        goto(c + 5); fire = 2'b00;
        goto(c + 9); chk("s4_busy", 32'(slot_busy), 32'h3);

        // Full pool, free of a busy slot and of an idle slot
        do_reset();
        c = cyc;
        setp(0, 0, 10, 10); setp(1, 1, 20, 20); fire = 2'b11;
        push(c + 2, 0, 0, 0, 10, 10);
        push(c + 3, 1, 1, 1, 20, 20);
        goto(c + 1); fire = 2'b00;
        goto(c + 10); setp(1, 2, 30, 30); fire = 2'b10;
        push(c + 12, 2, 1, 2, 30, 30);
        goto(c + 11); fire = 2'b00;
        goto(c + 12); setp(0, 3, 40, 40); fire = 2'b01;
        push(c + 14, 3, 0, 3, 40, 40);
        goto(c + 13); fire = 2'b00;
        goto(c + 16); chk("s5_full", 32'(slot_busy), 32'hf);
        goto(c + 20); setp(1, 0, 50, 51); fire = 2'b10;
        goto(c + 21); fire = 2'b00;
        goto(c + 25); slot_free = 4'b0100;
        push(c + 27, 2, 1, 0, 50, 51);
        goto(c + 26); slot_free = 4'b0000;
        goto(c + 28); chk("s5_refill", 32'(slot_busy), 32'hf);
        goto(c + 30); slot_free = 4'b1000;
        goto(c + 31); slot_free = 4'b0000;
        chk("s5_free3", 32'(slot_busy), 32'h7);
        goto(c + 33); slot_free = 4'b1000;
        goto(c + 34); slot_free = 4'b0000;
        goto(c + 35); chk("s5_idle_free", 32'(slot_busy), 32'h7);

        // game_over drops pending; reset mid-cooldown
        do_reset();
        c = cyc;
        setp(0, 1, 111, 222); fire = 2'b01;
        goto(c + 1); game_over = 1'b1;
        goto(c + 3); game_over = 1'b0;
        goto(c + 10); chk("s6_go_busy", 32'(slot_busy), 0);
        fire = 2'b00;
        goto(c + 12); setp(0, 2, 333, 444); fire = 2'b01;
        push(c + 14, 0, 0, 2, 333, 444);
        goto(c + 13); fire = 2'b00;
        goto(c + 15); reset = 1'b1;
        #1;
        chk("s6_rst_busy", 32'(slot_busy), 0);
        chk("s6_rst_xy", {22'd0, launch_x}, 0);
        chk("s6_rst_y", {22'd0, launch_y}, 0);
        chk("s6_rst_dir", 32'(launch_dir), 0);
        goto(c + 16); reset = 1'b0;
        setp(0, 3, 5, 9); fire = 2'b01;
        push(c + 18, 0, 0, 3, 5, 9);
        goto(c + 17); fire = 2'b00;
        goto(c + 20); chk("s6_busy", 32'(slot_busy), 32'h1);

        goto(cyc + 5);
        chk("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
